vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the pixel clock domain.
- Drives hsync/vsync to the connector.
- Feeds `column`, `row` and `disp_en` to the colour generator downstream.
- Produces `game_clk`, a once-per-frame level toggle whose rising edge falls at the start of vertical blanking, so game state updates while nothing is drawn.

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480@60 Hz by default).
//
// Ports:
//   vga_clk     in   pixel-domain clock, the only clock
//   reset       in   asynchronous, active-low reset
//   pix_ce      in   pixel clock enable; counters and outputs advance only when 1
//   hsync       out  horizontal sync, asserted level SYNC_POL
//   vsync       out  vertical sync, asserted level SYNC_POL
//   disp_en     out  current pixel lies inside the active area
//   column      out  active-area x coordinate (0 outside the active area)
//   row         out  active-area y coordinate (0 outside the active area)
//   game_clk    out  high during vertical blanking lines, low otherwise
//   frame_start out  one enabled-cycle pulse registered from pixel (0,0)
//
// All outputs are registered from the counter state, one enabled cycle of
// latency, so they stay mutually aligned.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       disp_en,
  output logic [9:0] column,
  output logic [8:0] row,
  output logic       game_clk,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_en_q, disp_en_d;
  logic [9:0] column_q, column_d;
  logic [8:0] row_q, row_d;
  logic       game_clk_q, game_clk_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    disp_en_d     = disp_en_q;
    column_d      = column_q;
    row_d         = row_q;
    game_clk_d    = game_clk_q;
    frame_start_d = frame_start_q;

    if (pix_ce) begin
      // Frame wrap goes straight from (H_MAX,V_MAX) to (0,0).
      if (h_cnt_q == H_MAX) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end

      // Outputs decode the pre-increment counter state.
      disp_en_d     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hsync_d       = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
      column_d      = disp_en_d ? h_cnt_q : '0;
      row_d         = disp_en_d ? v_cnt_q[8:0] : '0;
      game_clk_d    = (v_cnt_q >= V_ACT);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      disp_en_q     <= 1'b0;
      column_q      <= '0;
      row_q         <= '0;
      game_clk_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_en_q     <= disp_en_d;
      column_q      <= column_d;
      row_q         <= row_d;
      game_clk_q    <= game_clk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_en     = disp_en_q;
  assign column      = column_q;
  assign row         = row_q;
  assign game_clk    = game_clk_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen. Two instances share clock,
// reset and pix_ce: one with the default 640x480 geometry (line-level timing)
// and one with a tiny geometry and active-high syncs so whole frames fit in a
// short run. Expected outputs come from the raster position implied by the
// number of enabled edges since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] col;
    logic [8:0] row;
    logic       gc;
    logic       fs;
  } vout_t;

  // Default geometry
  localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  // Small geometry: 25 x 19 = 475 pixels per frame
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  logic vga_clk = 1'b0;
  logic reset   = 1'b0;
  logic pix_ce  = 1'b0;

  logic       hs_d, vs_d, de_d, gc_d, fs_d;
  logic [9:0] col_d;
  logic [8:0] row_d;
  logic       hs_s, vs_s, de_s, gc_s, fs_s;
  logic [9:0] col_s;
  logic [8:0] row_s;

  vout_t got_d, got_s, exp_d, exp_s;

  int n = 0;        // enabled edges since reset release
  int vectors = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(hs_d), .vsync(vs_d), .disp_en(de_d), .column(col_d), .row(row_d),
    .game_clk(gc_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b1)
  ) dut_s (
    .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(hs_s), .vsync(vs_s), .disp_en(de_s), .column(col_s), .row(row_s),
    .game_clk(gc_s), .frame_start(fs_s)
  );

  assign got_d = {hs_d, vs_d, de_d, col_d, row_d, gc_d, fs_d};
  assign got_s = {hs_s, vs_s, de_s, col_s, row_s, gc_s, fs_s};

  // Outputs after k enabled edges: edge k registers raster position k-1.
  function automatic vout_t model(input int k, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs,
                                  input int vb, input bit pol);
    vout_t o;
    int ht, vt, p, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    o.hs = ~pol; o.vs = ~pol; o.de = 1'b0; o.col = '0; o.row = '0;
    o.gc = 1'b0; o.fs = 1'b0;
    if (k > 0) begin
      p = (k - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      o.hs = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
      o.vs = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
      o.de = (h < ha) && (v < va);
      if (o.de) begin
        o.col = 10'(h);
        o.row = 9'(v);
      end
      o.gc = (v >= va);
      o.fs = (p == 0);
    end
    return o;
  endfunction

  function automatic vout_t model_d(input int k);
    return model(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, 1'b0);
  endfunction

  function automatic vout_t model_s(input int k);
    return model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1);
  endfunction

  // Drive pix_ce from a negedge and advance past the following posedge.
  task automatic step(input bit ce);
    pix_ce = ce;
    @(posedge vga_clk);
    if (ce && reset) n++;
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    @(negedge vga_clk);
    reset = 1'b0;
    pix_ce = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge vga_clk);
      exp_d = model_d(0); exp_s = model_s(0);
      vectors++;
      if (got_d !== exp_d) begin
        errors++; $display("FAIL reset_dflt: got %h exp %h", got_d, exp_d);
      end
      vectors++;
      if (got_s !== exp_s) begin
        errors++; $display("FAIL reset_small: got %h exp %h", got_s, exp_s);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      exp_d = model_d(n); exp_s = model_s(n);
      vectors++;
      if (got_d !== exp_d) begin
        errors++; $display("FAIL restart_dflt n=%0d: got %h exp %h", n, got_d, exp_d);
      end
      vectors++;
      if (got_s !== exp_s) begin
        errors++; $display("FAIL restart_small n=%0d: got %h exp %h", n, got_s, exp_s);
      end
    end
  endtask

  task automatic test_line_timing();
    for (int i = 0; i < 2500; i++) begin
      step(1'b1);
      exp_d = model_d(n); exp_s = model_s(n);
      vectors++;
      if (got_d !== exp_d) begin
        errors++; $display("FAIL line_dflt n=%0d: got %h exp %h", n, got_d, exp_d);
      end
      vectors++;
      if (got_s !== exp_s) begin
        errors++; $display("FAIL line_small n=%0d: got %h exp %h", n, got_s, exp_s);
      end
    end
  endtask

  task automatic test_frame_timing();
    int fs_pos[$];
    int gc_cnt, vs_cnt, t;
    gc_cnt = 0; vs_cnt = 0; t = 0;
    for (int i = 0; i < 3 * S_HT * S_VT + 10; i++) begin
      step(1'b1);
      t++;
      if (fs_s) fs_pos.push_back(t);
      if (fs_pos.size() == 1) begin
        if (gc_s) gc_cnt++;
        if (vs_s) vs_cnt++;
      end
      exp_s = model_s(n);
      vectors++;
      if (got_s !== exp_s) begin
        errors++; $display("FAIL frame_small n=%0d: got %h exp %h", n, got_s, exp_s);
      end
    end
    vectors++;
    if (fs_pos.size() < 2) begin
      errors++; $display("FAIL frame_start_count: got %0d exp >=2", fs_pos.size());
    end else if (fs_pos[1] - fs_pos[0] !== S_HT * S_VT) begin
      errors++; $display("FAIL frame_period: got %0d exp %0d", fs_pos[1] - fs_pos[0], S_HT * S_VT);
    end
    vectors++;
    if (gc_cnt !== (S_VT - S_VA) * S_HT) begin
      errors++; $display("FAIL game_clk_high: got %0d exp %0d", gc_cnt, (S_VT - S_VA) * S_HT);
    end
    vectors++;
    if (vs_cnt !== S_VS * S_HT) begin
      errors++; $display("FAIL vsync_width: got %0d exp %0d", vs_cnt, S_VS * S_HT);
    end
  endtask

  task automatic test_pix_ce_toggle();
    int hs_low;
    hs_low = 0;
    for (int i = 0; i < 3400; i++) begin
      step(i[0] == 1'b0);
      if (i >= 1600 && i < 3200 && !hs_d) hs_low++;
      exp_d = model_d(n); exp_s = model_s(n);
      vectors++;
      if (got_d !== exp_d) begin
        errors++; $display("FAIL toggle_dflt n=%0d: got %h exp %h", n, got_d, exp_d);
      end
      vectors++;
      if (got_s !== exp_s) begin
        errors++; $display("FAIL toggle_small n=%0d: got %h exp %h", n, got_s, exp_s);
      end
    end
    // A 1600-cycle window at half rate spans exactly one line: hsync low 192 cycles.
    vectors++;
    if (hs_low !== 2 * D_HS) begin
      errors++; $display("FAIL hsync_width_halfrate: got %0d exp %0d", hs_low, 2 * D_HS);
    end
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0));
      exp_d = model_d(n); exp_s = model_s(n);
      vectors++;
      if (got_d !== exp_d) begin
        errors++; $display("FAIL random_dflt n=%0d: got %h exp %h", n, got_d, exp_d);
      end
      vectors++;
      if (got_s !== exp_s) begin
        errors++; $display("FAIL random_small n=%0d: got %h exp %h", n, got_s, exp_s);
      end
    end
  endtask

  task automatic test_async_reset();
    // Small instance: stop at line 7, column 5 (mid active area).
    int target;
    target = 7 * S_HT + 5 + 1;
    while ((n % (S_HT * S_VT)) != target) step(1'b1);
    @(posedge vga_clk);
    n++;
    #2;
    reset = 1'b0;
    n = 0;
    #1;
    exp_d = model_d(0); exp_s = model_s(0);
    vectors++;
    if (got_d !== exp_d) begin
      errors++; $display("FAIL async_reset_dflt: got %h exp %h", got_d, exp_d);
    end
    vectors++;
    if (got_s !== exp_s) begin
      errors++; $display("FAIL async_reset_small: got %h exp %h", got_s, exp_s);
    end
    test_reset();
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_pix_ce_toggle();
    test_random_ce();
    test_async_reset();
    test_random_ce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
